// File: rtl/peri_timer_resp_pkg.sv
// Shared definitions for the peripheral-bus timer: base address, register map,
// CTRL layout, STATUS bit positions and the byte-strobe merge helper.
package peri_timer_resp_pkg;

  localparam logic [15:0] BASE_ADDR_TIMER = 16'h1003;
  localparam logic [31:0] TIMER_ID        = 32'h5449_4D31;

  // Word index taken from addr[7:2]
  typedef enum logic [5:0] {
    REG_CTRL     = 6'h00,
    REG_PRESCALE = 6'h01,
    REG_COUNT    = 6'h02,
    REG_COMPARE  = 6'h03,
    REG_STATUS   = 6'h04,
    REG_ID       = 6'h05
  } reg_idx_e;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  localparam int STAT_MATCH   = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_RUNNING = 8;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/peri_timer_resp_if.sv
// One-stage peripheral bus slot: single-cycle requests, one-cycle response pulse.
interface peri_timer_resp_if;
  logic [31:0] addr_32b;
  logic        wren;
  logic        rden;
  logic [31:0] din_32b;
  logic [3:0]  wstrb;
  logic        dout_32b_valid;
  logic [31:0] dout_32b;

  modport master (output addr_32b, wren, rden, din_32b, wstrb,
                  input  dout_32b_valid, dout_32b);
  modport slave  (input  addr_32b, wren, rden, din_32b, wstrb,
                  output dout_32b_valid, dout_32b);
endinterface

// File: rtl/peri_timer_resp_core.sv
// Prescaler and 32-bit counter; emits single-cycle tick / match / overflow pulses.
module peri_timer_resp_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic        auto_reload,
  input  logic [15:0] prescale,
  input  logic [31:0] compare,
  input  logic        prescale_we,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  output logic [31:0] count,
  output logic        tick,
  output logic        match_set,
  output logic        ovf_set
);

  logic [15:0] pcnt;
  logic        tick_due;
  logic [32:0] count_inc;

  // A software write to COUNT swallows a tick that falls in the same cycle.
  assign tick_due  = en && (pcnt == prescale);
  assign tick      = tick_due && !count_we;
  assign match_set = tick && (count == compare);
  assign count_inc = {1'b0, count} + 33'd1;
  assign ovf_set   = tick && count_inc[32] && !(match_set && auto_reload);

  // NOTE: non-blocking (<=) in sequential blocks so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt  <= '0;
      count <= '0;
    end else begin
      if (!en || prescale_we || count_we || tick_due) pcnt <= '0;
      else                                            pcnt <= pcnt + 16'd1;

      if (count_we)                       count <= count_wdata;
      else if (match_set && auto_reload)  count <= '0;
      else if (tick)                      count <= count_inc[31:0];
    end
  end

endmodule

// File: rtl/peri_timer_resp.sv
// Timer responder: bus decode, register bank with byte strobes, W1C status,
// registered one-cycle response and registered level interrupt.
module peri_timer_resp
  import peri_timer_resp_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BASE_ADDR_TIMER,
  parameter logic [31:0] ID_VALUE  = TIMER_ID
) (
  input  logic               clk_i,
  input  logic               rst_i,
  peri_timer_resp_if.slave   bus,
  output logic               irq_o
);

  ctrl_t       ctrl;
  logic [15:0] prescale;
  logic [31:0] compare;
  logic [31:0] count;
  logic        match, ovf;
  logic        resp_valid;
  logic [31:0] resp_data;

  logic        req, wr_hit;
  reg_idx_e    idx;
  logic        ctrl_we, prescale_we, count_we, compare_we, status_we;
  logic [31:0] ctrl_m, pre_m, cmp_m, cnt_m;
  logic [1:0]  w1c;
  logic [31:0] status_rd, rdata;
  logic        core_tick, match_set, ovf_set;

  // A write with no strobes set is acknowledged but has no side effects.
  assign req         = (bus.wren || bus.rden) && (bus.addr_32b[31:16] == BASE_ADDR);
  assign wr_hit      = req && bus.wren && (|bus.wstrb);
  assign idx         = reg_idx_e'(bus.addr_32b[7:2]);
  assign ctrl_we     = wr_hit && (idx == REG_CTRL);
  assign prescale_we = wr_hit && (idx == REG_PRESCALE);
  assign count_we    = wr_hit && (idx == REG_COUNT);
  assign compare_we  = wr_hit && (idx == REG_COMPARE);
  assign status_we   = wr_hit && (idx == REG_STATUS);

  assign ctrl_m = apply_wstrb({29'b0, ctrl},    bus.din_32b, bus.wstrb);
  assign pre_m  = apply_wstrb({16'b0, prescale}, bus.din_32b, bus.wstrb);
  assign cmp_m  = apply_wstrb(compare,          bus.din_32b, bus.wstrb);
  assign cnt_m  = apply_wstrb(count,            bus.din_32b, bus.wstrb);
  assign w1c    = (status_we && bus.wstrb[0]) ? bus.din_32b[1:0] : 2'b00;

  peri_timer_resp_core u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en          (ctrl.en),
    .auto_reload (ctrl.auto_reload),
    .prescale    (prescale),
    .compare     (compare),
    .prescale_we (prescale_we),
    .count_we    (count_we),
    .count_wdata (cnt_m),
    .count       (count),
    .tick        (core_tick),
    .match_set   (match_set),
    .ovf_set     (ovf_set)
  );

  always_comb begin
    status_rd               = '0;
    status_rd[STAT_MATCH]   = match;
    status_rd[STAT_OVF]     = ovf;
    status_rd[STAT_RUNNING] = ctrl.en;
  end

  always_comb begin
    // NOTE: default assignment first; without it an unlisted case infers a latch.
    rdata = '0;
    case (idx)
      REG_CTRL:     rdata = {29'b0, ctrl};
      REG_PRESCALE: rdata = {16'b0, prescale};
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status_rd;
      REG_ID:       rdata = ID_VALUE;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl       <= '0;
      prescale   <= '0;
      compare    <= '1;
      match      <= 1'b0;
      ovf        <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (ctrl_we)     ctrl     <= ctrl_t'(ctrl_m[2:0]);
      if (prescale_we) prescale <= pre_m[15:0];
      if (compare_we)  compare  <= cmp_m;
      // Hardware set takes priority over a simultaneous W1C.
      match      <= match_set | (match & ~w1c[STAT_MATCH]);
      ovf        <= ovf_set   | (ovf   & ~w1c[STAT_OVF]);
      irq_o      <= ctrl.irq_en & (match | ovf);
      resp_valid <= req;
      resp_data  <= (req && !bus.wren) ? rdata : '0;
    end
  end

  assign bus.dout_32b_valid = resp_valid;
  assign bus.dout_32b       = resp_data;

  logic unused_ok;
  assign unused_ok = ^{bus.addr_32b[15:8], bus.addr_32b[1:0], ctrl_m[31:3], pre_m[31:16], core_tick};

endmodule

// File: tb/tb_peri_timer_resp.sv
// Self-checking bench for peri_timer_resp: vector table, directed corner sequences
// and a randomized run compared every cycle against a register-level reference model.
module tb_peri_timer_resp;

  localparam logic [15:0] BASE = 16'h1003;
  localparam logic [31:0] ID   = 32'h5449_4D31;
  localparam int          NVEC = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   checks   = 0;
  int   failures = 0;

  peri_timer_resp_if bus ();

  peri_timer_resp #(.BASE_ADDR(BASE), .ID_VALUE(ID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (register-level view) ----------------
  logic        m_en, m_ar, m_ie;
  logic [15:0] m_pre;
  logic [31:0] m_cnt, m_cmp;
  logic        m_match, m_ovf;
  int          m_phase;
  logic        exp_valid, exp_irq;
  logic [31:0] exp_dout;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (n & mask) | (o & ~mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00:   return {29'b0, m_ie, m_ar, m_en};
      8'h04:   return {16'b0, m_pre};
      8'h08:   return m_cnt;
      8'h0C:   return m_cmp;
      8'h10:   return {23'b0, m_en, 6'b0, m_ovf, m_match};
      8'h14:   return ID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_cycle(input logic r, input logic wr, input logic rd,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic        hit, w, tick, cnt_wr, set_m, set_o;
    logic [7:0]  off;
    logic [32:0] inc;
    logic [31:0] nxt, tmp;
    if (r) begin
      {m_en, m_ar, m_ie} = 3'b000;
      m_pre = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF;
      m_match = 1'b0; m_ovf = 1'b0; m_phase = 0;
      exp_valid = 1'b0; exp_dout = '0; exp_irq = 1'b0;
    end else begin
      hit = (wr || rd) && (a[31:16] == BASE);
      w   = hit && wr && (s != 4'h0);
      off = {a[7:2], 2'b00};
      exp_valid = hit;
      exp_dout  = (hit && !wr) ? m_read(off) : 32'h0;
      exp_irq   = m_ie && (m_match || m_ovf);
      tick   = m_en && (m_phase == int'(m_pre));
      cnt_wr = w && (off == 8'h08);
      set_m = 1'b0; set_o = 1'b0; nxt = m_cnt;
      if (tick && !cnt_wr) begin
        inc = {1'b0, m_cnt} + 33'd1;
        if (m_cnt == m_cmp) begin
          set_m = 1'b1;
          if (m_ar) nxt = 32'h0;
          else begin nxt = inc[31:0]; set_o = inc[32]; end
        end else begin
          nxt = inc[31:0]; set_o = inc[32];
        end
      end
      if (!m_en || cnt_wr || (w && off == 8'h04)) m_phase = 0;
      else m_phase = (m_phase + 1) % (int'(m_pre) + 1);
      if (w && off == 8'h10 && s[0]) begin
        if (d[0]) m_match = 1'b0;
        if (d[1]) m_ovf = 1'b0;
      end
      if (set_m) m_match = 1'b1;
      if (set_o) m_ovf = 1'b1;
      m_cnt = cnt_wr ? merge(m_cnt, d, s) : nxt;
      if (w && off == 8'h00) begin
        tmp = merge({29'b0, m_ie, m_ar, m_en}, d, s);
        {m_ie, m_ar, m_en} = tmp[2:0];
      end
      if (w && off == 8'h04) begin
        tmp = merge({16'b0, m_pre}, d, s);
        m_pre = tmp[15:0];
      end
      if (w && off == 8'h0C) m_cmp = merge(m_cmp, d, s);
    end
  endtask

  // One bus cycle: check outputs from the previous edge, drive new inputs, advance model.
  task automatic step(input logic r, input logic wr, input logic rd,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    check("model valid", 32'(bus.dout_32b_valid), 32'(exp_valid));
    check("model dout",  bus.dout_32b, exp_dout);
    check("model irq",   32'(irq), 32'(exp_irq));
    rst = r; bus.wren = wr; bus.rden = rd; bus.addr_32b = a; bus.din_32b = d; bus.wstrb = s;
    model_cycle(r, wr, rd, a, d, s);
  endtask

  function automatic logic [31:0] A(input logic [7:0] off);
    return {BASE, 8'h00, off};
  endfunction

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask
  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask
  task automatic wr_reg(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    step(1'b0, 1'b1, 1'b0, A(off), d, s);
  endtask
  task automatic rd_reg(input logic [7:0] off);
    step(1'b0, 1'b0, 1'b1, A(off), 32'h0, 4'h0);
  endtask
  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  strb;
    logic        exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.din = d; v.strb = s; v.exp_valid = ev; v.exp_dout = ed;
    return v;
  endfunction

  initial begin
    int          n;
    logic        r, wr, rd;
    logic [15:0] base;
    logic [7:0]  off;
    logic [31:0] d;
    logic [3:0]  s;

    bus.wren = 1'b0; bus.rden = 1'b0; bus.addr_32b = '0; bus.din_32b = '0; bus.wstrb = '0;
    model_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset valid", 32'(bus.dout_32b_valid), 32'h0);
    check("reset dout",  bus.dout_32b, 32'h0);
    check("reset irq",   32'(irq), 32'h0);

    tbl[0]  = mk(1'b0, 1'b1, A(8'h0C), 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFF);
    tbl[1]  = mk(1'b0, 1'b1, A(8'h14), 32'h0, 4'h0, 1'b1, ID);
    tbl[2]  = mk(1'b0, 1'b1, A(8'h00), 32'h0, 4'h0, 1'b1, 32'h0);
    tbl[3]  = mk(1'b0, 1'b1, A(8'h10), 32'h0, 4'h0, 1'b1, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, {BASE + 16'd1, 16'h0014}, 32'h0, 4'h0, 1'b0, 32'h0);
    tbl[5]  = mk(1'b1, 1'b0, A(8'h08), 32'h1234_5678, 4'b0010, 1'b1, 32'h0);
    tbl[6]  = mk(1'b0, 1'b1, A(8'h08), 32'h0, 4'h0, 1'b1, 32'h0000_5600);
    tbl[7]  = mk(1'b1, 1'b0, A(8'h04), 32'h0001_ABCD, 4'b0011, 1'b1, 32'h0);
    tbl[8]  = mk(1'b0, 1'b1, A(8'h04), 32'h0, 4'h0, 1'b1, 32'h0000_ABCD);
    tbl[9]  = mk(1'b1, 1'b0, A(8'h0C), 32'hAA00_0000, 4'b1000, 1'b1, 32'h0);
    tbl[10] = mk(1'b0, 1'b1, A(8'h0C), 32'h0, 4'h0, 1'b1, 32'hAAFF_FFFF);
    tbl[11] = mk(1'b1, 1'b1, A(8'h00), 32'h0000_0006, 4'b0001, 1'b1, 32'h0);
    tbl[12] = mk(1'b0, 1'b1, A(8'h00), 32'h0, 4'h0, 1'b1, 32'h0000_0006);
    tbl[13] = mk(1'b0, 1'b1, A(8'h18), 32'h0, 4'h0, 1'b1, 32'h0);
    tbl[14] = mk(1'b1, 1'b0, A(8'h1C), 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    tbl[15] = mk(1'b1, 1'b0, A(8'h14), 32'h0, 4'hF, 1'b1, 32'h0);
    tbl[16] = mk(1'b0, 1'b1, A(8'h14), 32'h0, 4'h0, 1'b1, ID);
    tbl[17] = mk(1'b0, 1'b1, A(8'h10), 32'h0, 4'h0, 1'b1, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      step(1'b0, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].strb);
      sample();
      check($sformatf("tbl[%0d] valid", i), 32'(bus.dout_32b_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl[%0d] dout", i),  bus.dout_32b, tbl[i].exp_dout);
    end
    idle();
    sample();
    check("tbl idle valid", 32'(bus.dout_32b_valid), 32'h0);
    check("tbl idle dout",  bus.dout_32b, 32'h0);

    // Compare match with auto-reload and interrupt.
    do_reset();
    wr_reg(8'h04, 32'd3, 4'hF);
    wr_reg(8'h0C, 32'd5, 4'hF);
    wr_reg(8'h00, 32'd7, 4'hF);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      idle();
      sample();
      if (irq) begin
        n = i;
        break;
      end
    end
    check("match irq latency", n, 32'd25);
    rd_reg(8'h08);
    sample();
    check("reload count", bus.dout_32b, 32'h0);
    rd_reg(8'h10);
    sample();
    check("match status", bus.dout_32b, 32'h0000_0101);

    // Overflow wrap; compare still at reset value so MATCH also sets.
    do_reset();
    wr_reg(8'h08, 32'hFFFF_FFFE, 4'hF);
    wr_reg(8'h00, 32'd1, 4'h1);
    idle();
    idle();
    rd_reg(8'h10);
    sample();
    check("ovf status", bus.dout_32b, 32'h0000_0103);
    check("ovf irq off", 32'(irq), 32'h0);

    // W1C in the same cycle as a hardware match: the set must win.
    do_reset();
    wr_reg(8'h0C, 32'd3, 4'hF);
    wr_reg(8'h00, 32'd7, 4'hF);
    repeat (7) idle();
    wr_reg(8'h10, 32'h1, 4'h1);
    wr_reg(8'h10, 32'h1, 4'h1);
    sample();
    check("w1c set wins irq", 32'(irq), 32'h1);
    rd_reg(8'h10);
    sample();
    check("w1c cleared irq", 32'(irq), 32'h0);
    check("w1c status", bus.dout_32b, 32'h0000_0100);

    // Reset during a transaction drops the response and the write.
    rd_reg(8'h14);
    step(1'b1, 1'b1, 1'b0, A(8'h0C), 32'h1234, 4'hF);
    sample();
    check("rst drop valid", 32'(bus.dout_32b_valid), 32'h0);
    rd_reg(8'h0C);
    sample();
    check("rst write ignored", bus.dout_32b, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      wr   = 1'($urandom_range(0, 1));
      rd   = !wr || ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin wr = 1'b0; rd = 1'b0; end
      base = ($urandom_range(0, 15) == 0) ? (BASE ^ 16'h0100) : BASE;
      off  = 8'($urandom_range(0, 7) * 4);
      s    = 4'($urandom_range(1, 15));
      case (off)
        8'h00:   d = 32'($urandom_range(0, 7));
        8'h04:   d = 32'($urandom_range(0, 3));
        8'h08:   d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom_range(0, 20));
        8'h0C:   d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
        default: d = $urandom();
      endcase
      step(r, wr, rd, {base, 8'($urandom_range(0, 255)), off | 8'($urandom_range(0, 3))}, d, s);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
